// File: rtl/hood_mode_control.sv
// hood_mode_control: operating-mode sequencer for the range hood.
// Follows the upstream machine_state power level and walks the hood through
// standby, fan levels 1/2/3 (level 3 timed, once per power-on) and a timed
// self-clean cycle. Every output comes straight from a flop.
module hood_mode_control #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter int unsigned LEVEL3_SEC    = 60,
    parameter int unsigned CLEAN_SEC     = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       machine_state,
    input  logic       lvl1_btn,
    input  logic       lvl2_btn,
    input  logic       lvl3_btn,
    input  logic       clean_btn,
    input  logic       standby_btn,
    output logic [2:0] mode,
    output logic [1:0] fan_level,
    output logic [7:0] remaining_sec,
    output logic       level3_locked,
    output logic       clean_done
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STANDBY = 3'd1,
        ST_L1      = 3'd2,
        ST_L2      = 3'd3,
        ST_L3      = 3'd4,
        ST_CLEAN   = 3'd5
    } state_t;

    // Prescaler is at least one bit wide so TICKS_PER_SEC == 1 still elaborates.
    localparam int unsigned PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]    L3_LOAD  = 8'(LEVEL3_SEC);
    localparam logic [7:0]    CLN_LOAD = 8'(CLEAN_SEC);

    state_t        state;
    logic [PW-1:0] prescaler;

    // The state register doubles as the mode code, so mode is registered.
    assign mode = state;

    // Mode sequencer, one-second timer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_OFF;
            fan_level     <= 2'd0;
            remaining_sec <= '0;
            level3_locked <= 1'b0;
            clean_done    <= 1'b0;
            prescaler     <= '0;
        end else begin
            clean_done <= 1'b0;
            if (!machine_state) begin
                // Power loss wins over everything, including buttons and timers.
                state         <= ST_OFF;
                fan_level     <= 2'd0;
                remaining_sec <= '0;
                level3_locked <= 1'b0;
                prescaler     <= '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        state     <= ST_STANDBY;
                        fan_level <= 2'd0;
                    end

                    ST_STANDBY, ST_L1, ST_L2: begin
                        // A locked lvl3 press falls through so lower-priority
                        // presses in the same cycle are still honoured.
                        if (lvl3_btn && !level3_locked) begin
                            state         <= ST_L3;
                            fan_level     <= 2'd3;
                            remaining_sec <= L3_LOAD;
                            level3_locked <= 1'b1;
                            prescaler     <= '0;
                        end else if (lvl2_btn) begin
                            state     <= ST_L2;
                            fan_level <= 2'd2;
                        end else if (lvl1_btn) begin
                            state     <= ST_L1;
                            fan_level <= 2'd1;
                        end else if (clean_btn && (state == ST_STANDBY)) begin
                            state         <= ST_CLEAN;
                            fan_level     <= 2'd0;
                            remaining_sec <= CLN_LOAD;
                            prescaler     <= '0;
                        end else if (standby_btn && (state != ST_STANDBY)) begin
                            state     <= ST_STANDBY;
                            fan_level <= 2'd0;
                        end
                    end

                    ST_L3, ST_CLEAN: begin
                        if (prescaler == PRE_MAX) begin
                            prescaler <= '0;
                            // The <= 1 guard also keeps the count from wrapping below 0.
                            if (remaining_sec <= 8'd1) begin
                                remaining_sec <= '0;
                                state         <= ST_STANDBY;
                                fan_level     <= 2'd0;
                                clean_done    <= (state == ST_CLEAN);
                            end else begin
                                remaining_sec <= remaining_sec - 8'd1;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end

                    default: begin
                        state         <= ST_OFF;
                        fan_level     <= 2'd0;
                        remaining_sec <= '0;
                        prescaler     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hood_mode_control.sv
// tb_hood_mode_control: scoreboard bench for hood_mode_control.
// A behavioural model pushes the expected outputs for each edge; they are
// popped and compared one time unit after that edge. Directed checks with
// literal values cover the key scenarios, followed by a random burst.
module tb_hood_mode_control;

    localparam int unsigned TPS = 4;
    localparam int unsigned L3S = 3;
    localparam int unsigned CS  = 5;

    localparam logic [4:0] B_L1 = 5'b00001;
    localparam logic [4:0] B_L2 = 5'b00010;
    localparam logic [4:0] B_L3 = 5'b00100;
    localparam logic [4:0] B_CL = 5'b01000;
    localparam logic [4:0] B_SB = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       machine_state = 1'b0;
    logic       lvl1_btn = 1'b0, lvl2_btn = 1'b0, lvl3_btn = 1'b0;
    logic       clean_btn = 1'b0, standby_btn = 1'b0;
    logic [2:0] mode;
    logic [1:0] fan_level;
    logic [7:0] remaining_sec;
    logic       level3_locked;
    logic       clean_done;

    hood_mode_control #(
        .TICKS_PER_SEC(TPS),
        .LEVEL3_SEC   (L3S),
        .CLEAN_SEC    (CS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .machine_state(machine_state),
        .lvl1_btn     (lvl1_btn),
        .lvl2_btn     (lvl2_btn),
        .lvl3_btn     (lvl3_btn),
        .clean_btn    (clean_btn),
        .standby_btn  (standby_btn),
        .mode         (mode),
        .fan_level    (fan_level),
        .remaining_sec(remaining_sec),
        .level3_locked(level3_locked),
        .clean_done   (clean_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mode;
        logic [7:0] fan;
        logic [7:0] rem;
        logic [7:0] lock;
        logic [7:0] done;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state
    int m_mode = 0;
    int m_rem  = 0;
    int m_pre  = 0;
    int m_lock = 0;
    int m_done = 0;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int fan_of(input int md);
        case (md)
            2: return 1;
            3: return 2;
            4: return 3;
            default: return 0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        m_done = 0;
        if (!rst) begin
            m_mode = 0; m_rem = 0; m_pre = 0; m_lock = 0;
        end else if (!machine_state) begin
            m_mode = 0; m_rem = 0; m_pre = 0; m_lock = 0;
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1, 2, 3: begin
                    if (lvl3_btn && m_lock == 0) begin
                        m_mode = 4; m_rem = L3S; m_lock = 1; m_pre = 0;
                    end else if (lvl2_btn) m_mode = 3;
                    else if (lvl1_btn) m_mode = 2;
                    else if (clean_btn && m_mode == 1) begin
                        m_mode = 5; m_rem = CS; m_pre = 0;
                    end else if (standby_btn && m_mode != 1) m_mode = 1;
                end
                default: begin
                    if (m_pre == TPS - 1) begin
                        m_pre = 0;
                        if (m_rem == 1) begin
                            m_rem = 0;
                            if (m_mode == 5) m_done = 1;
                            m_mode = 1;
                        end else begin
                            m_rem = m_rem - 1;
                        end
                    end else begin
                        m_pre = m_pre + 1;
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e.mode = 8'(m_mode);
        e.fan  = 8'(fan_of(m_mode));
        e.rem  = 8'(m_rem);
        e.lock = 8'(m_lock);
        e.done = 8'(m_done);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("mode", 8'(mode), e.mode);
        check_eq("fan_level", 8'(fan_level), e.fan);
        check_eq("remaining_sec", remaining_sec, e.rem);
        check_eq("level3_locked", 8'(level3_locked), e.lock);
        check_eq("clean_done", 8'(clean_done), e.done);
        {standby_btn, clean_btn, lvl3_btn, lvl2_btn, lvl1_btn} = '0;
    endtask

    task automatic pulse(input logic [4:0] btns);
        {standby_btn, clean_btn, lvl3_btn, lvl2_btn, lvl1_btn} = btns;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        // Reset, then power on into STANDBY
        rst = 1'b0; machine_state = 1'b0;
        idle(2);
        check_eq("rst_mode", 8'(mode), 8'd0);
        check_eq("rst_rem", remaining_sec, 8'd0);
        rst = 1'b1; machine_state = 1'b1;
        tick();
        check_eq("on_mode", 8'(mode), 8'd1);
        check_eq("on_fan", 8'(fan_level), 8'd0);
        check_eq("on_rem", remaining_sec, 8'd0);

        // Level 3 run and lock-out
        pulse(B_L3);
        check_eq("l3_mode", 8'(mode), 8'd4);
        check_eq("l3_fan", 8'(fan_level), 8'd3);
        check_eq("l3_rem", remaining_sec, 8'd3);
        check_eq("l3_lock", 8'(level3_locked), 8'd1);
        idle(4);
        check_eq("l3_rem_4", remaining_sec, 8'd2);
        idle(4);
        check_eq("l3_rem_8", remaining_sec, 8'd1);
        idle(3);
        check_eq("l3_mode_11", 8'(mode), 8'd4);
        tick();
        check_eq("l3_exit_mode", 8'(mode), 8'd1);
        check_eq("l3_exit_rem", remaining_sec, 8'd0);
        pulse(B_L3);
        check_eq("l3_relock_mode", 8'(mode), 8'd1);

        // Self-clean with ignored lvl1 presses
        pulse(B_CL);
        check_eq("cl_mode", 8'(mode), 8'd5);
        check_eq("cl_rem", remaining_sec, 8'd5);
        for (int i = 1; i <= 20; i++) begin
            if (i == 3 || i == 10) lvl1_btn = 1'b1;
            tick();
            if (i == 19) check_eq("cl_mode_19", 8'(mode), 8'd5);
        end
        check_eq("cl_exit_mode", 8'(mode), 8'd1);
        check_eq("cl_done", 8'(clean_done), 8'd1);
        tick();
        check_eq("cl_done_clr", 8'(clean_done), 8'd0);

        // Simultaneous lvl3+lvl1 from L2, unlocked then locked
        machine_state = 1'b0; tick();
        machine_state = 1'b1; tick();
        pulse(B_L2);
        check_eq("l2_mode", 8'(mode), 8'd3);
        pulse(B_L3 | B_L1);
        check_eq("pri_unlocked", 8'(mode), 8'd4);
        idle(12);
        check_eq("pri_l3_exit", 8'(mode), 8'd1);
        pulse(B_L2);
        pulse(B_L3 | B_L1);
        check_eq("pri_locked", 8'(mode), 8'd2);

        // L1: clean ignored, standby honoured
        pulse(B_CL);
        check_eq("l1_clean_ign", 8'(mode), 8'd2);
        pulse(B_SB);
        check_eq("l1_standby", 8'(mode), 8'd1);

        // Power loss mid-clean
        pulse(B_CL);
        idle(8);
        check_eq("mid_cl_rem", remaining_sec, 8'd3);
        check_eq("mid_cl_lock", 8'(level3_locked), 8'd1);
        machine_state = 1'b0;
        tick();
        check_eq("pwr_mode", 8'(mode), 8'd0);
        check_eq("pwr_rem", remaining_sec, 8'd0);
        check_eq("pwr_lock", 8'(level3_locked), 8'd0);
        check_eq("pwr_done", 8'(clean_done), 8'd0);

        // Reset mid-L3
        machine_state = 1'b1; tick();
        pulse(B_L3);
        idle(2);
        rst = 1'b0;
        tick();
        check_eq("rst_l3_mode", 8'(mode), 8'd0);
        check_eq("rst_l3_fan", 8'(fan_level), 8'd0);
        check_eq("rst_l3_rem", remaining_sec, 8'd0);
        check_eq("rst_l3_lock", 8'(level3_locked), 8'd0);
        rst = 1'b1;
        tick();

        // Random burst against the model
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 99) != 0);
            machine_state = ($urandom_range(0, 39) != 0);
            {standby_btn, clean_btn, lvl3_btn, lvl2_btn, lvl1_btn} =
                5'($urandom) & 5'($urandom) & 5'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
